muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the shared 33-bit iterative Multiplier unit for RV32M ops issued by the EX stage.
//  Sign/zero-extends rs1/rs2 to 33 bits per funct3, pulses Run, waits for ready, selects the result word.
//  Resolves div-by-zero and signed-overflow cases without using the unit. Stalls EX while busy.
// PARAMETERS
//  XLEN           32  operand/result width; unit operand width is XLEN+1
//  TIMEOUT_CYCLES 80  max WAIT cycles before forced completion with err
// PORTS
//  Clk         in   1   clock; all state updates on posedge
//  Reset       in   1   synchronous, active-high
//  req_valid   in   1   EX holds high with stable operands until resp_valid
//  req_funct3  in   3   RV32M funct3 (000 MUL .. 111 REMU)
//  req_rs1     in   32  operand 1
//  req_rs2     in   32  operand 2
//  busy        out  1   EX stall; high in every non-IDLE state
//  resp_valid  out  1   one-cycle pulse; resp_data valid the same cycle
//  resp_data   out  32  result word
//  err         out  1   pulses with resp_valid on timeout
//  Run         out  1   start pulse to unit (exactly 1 cycle)
//  div         out  1   0 = multiply, 1 = divide; held stable LAUNCH..DONE
//  opA, opB    out  33  unit operands; held stable LAUNCH..DONE
//  Aval, Bval  in   33  unit result: mul {Aval,Bval} = 66-bit product; div Aval = rem, Bval = quot
//  ready       in   1   unit idle/result valid; unit drops it the cycle after sampling Run
// BEHAVIOUR
//  Reset: state IDLE; Run, busy, resp_valid, err, div = 0; opA, opB, resp_data = 0; timeout counter 0.
//   Reset mid-op aborts; no resp_valid for the aborted op.
//  Extension: MUL/MULH/DIV/REM sign-extend both; MULHSU sign rs1, zero rs2; MULHU/DIVU/REMU zero both.
//  FSM:
//   IDLE   : req_valid & special case -> DONE.
//            req_valid & ready -> LAUNCH (latch opA/opB/div/funct3).
//            req_valid & !ready -> stay IDLE (unit still busy after reset).
//   LAUNCH : Run = 1 for this cycle only; ready ignored; -> WAIT.
//   WAIT   : ready -> DONE (capture result); count cycles; count == TIMEOUT_CYCLES -> DONE with err, resp_data 0.
//   DONE   : resp_valid = 1; -> IDLE. req_valid seen in the next IDLE cycle is a new op (EX advances on resp_valid).
//  Result select: MUL = Bval[31:0]; MULH/MULHSU/MULHU = {Aval[30:0], Bval[32]} (product[63:32]);
//   DIV/DIVU = Bval[31:0]; REM/REMU = Aval[31:0].
//  Specials (unit not started, 2-cycle latency IDLE->DONE):
//   rs2 == 0: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> rs1.
//   DIV rs1 = 32'h80000000, rs2 = 32'hFFFFFFFF -> 32'h80000000; REM same operands -> 0.
//  Normal latency: unit cycles + 3 (IDLE, LAUNCH, DONE). resp_data holds until next resp_valid.
// CONFIGURATION
//  MDU_RESULT_CACHE_EN defined: stores last rs1, rs2, op class and 66-bit {Aval,Bval}.
//   Op classes: {MUL,MULH}, {MULHSU}, {MULHU}, {DIV,REM}, {DIVU,REMU}.
//   A hit in IDLE goes IDLE -> DONE (2-cycle latency, no Run) and selects from the stored value.
//   The cache is invalidated on Reset and on timeout, and filled on each normal WAIT->DONE.
//  MDU_RESULT_CACHE_EN undefined: no cache storage; every non-special op launches the unit.
// TESTING
//  MULH rs1 = -3, rs2 = 7 -> opA = 33'h1FFFFFFFD, opB = 7, one Run pulse, resp_data = 32'hFFFFFFFF.
//  MUL rs1 = 0, rs2 = 500 -> resp_data = 0; busy high from the cycle after req until the cycle after resp_valid.
//  DIVU rs2 = 0, rs1 = 9 -> no Run, resp_valid 2 cycles after req, data = FFFFFFFF; REMU -> 9.
//  DIV rs1 = 80000000, rs2 = FFFFFFFF -> data = 80000000, no Run; REM -> 0.
//  Stub unit that never raises ready -> resp_valid and err after TIMEOUT_CYCLES; data = 0.
//  Reset asserted in WAIT -> next cycle IDLE, all outputs 0, no resp_valid.
//  Cache builds: MULH then MUL with the same operands -> second op returns in 2 cycles with no Run.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: drives the shared 33-bit iterative multiply/divide unit for RV32M ops from EX.
//
// The operands are sign- or zero-extended to XLEN+1 bits according to funct3. Run is pulsed for
// one cycle, then the block waits for ready and selects the result word. Divide-by-zero and the
// signed-overflow divide are answered directly, without starting the unit. EX is stalled (busy)
// whenever the FSM is not idle.
//
// Optional build macro MDU_RESULT_CACHE_EN:
//   Keeps the operands, op class and full {Aval,Bval} of the last unit result. A matching request
//   is answered from that copy without starting the unit.
//
// Ports:
//   Clk, Reset           clock; synchronous active-high reset
//   req_valid            EX request; operands stay stable until resp_valid
//   req_funct3           RV32M funct3
//   req_rs1, req_rs2     operands
//   busy                 EX stall, high in every non-idle state
//   resp_valid           one-cycle response pulse
//   resp_data            result word, held until the next response
//   err                  pulses with resp_valid when the unit timed out
//   Run                  one-cycle start pulse to the unit
//   div                  unit mode: 0 = multiply, 1 = divide
//   opA, opB             unit operands
//   Aval, Bval           unit result (mul: 66-bit product; div: Aval = rem, Bval = quot)
//   ready                unit idle / result valid
module muldiv_sequencer #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 80
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            busy,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            err,
    output logic            Run,
    output logic            div,
    output logic [XLEN:0]   opA,
    output logic [XLEN:0]   opB,
    input  logic [XLEN:0]   Aval,
    input  logic [XLEN:0]   Bval,
    input  logic            ready
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
    localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = '1;

    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

    state_e state_q, state_d;

    logic [XLEN:0]   opa_q, opb_q;
    logic            div_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] resp_data_q;
    logic            err_q;
    logic [CntW-1:0] cnt_q;

    // Pick the result word out of the unit's {Aval,Bval} for the given op.
    function automatic logic [XLEN-1:0] select_result(input logic [2:0]        f3,
                                                      input logic [2*XLEN+1:0] ab);
        logic [XLEN:0] a;
        logic [XLEN:0] b;
        a = ab[2*XLEN+1:XLEN+1];
        b = ab[XLEN:0];
        case (f3)
            F3Mul, F3Div, F3Divu:       select_result = b[XLEN-1:0];
            F3Mulh, F3Mulhsu, F3Mulhu:  select_result = {a[XLEN-2:0], b[XLEN]};
            default:                    select_result = a[XLEN-1:0];
        endcase
    endfunction

    // Operand extension and special-case decode for the incoming request.
    logic            sign_a, sign_b;
    logic [XLEN:0]   ext_a, ext_b;
    logic            div_by_zero, div_overflow, special;
    logic [XLEN-1:0] special_data;
    logic            timeout;
    logic            cache_hit;
    logic [2*XLEN+1:0] cache_val;

    always_comb begin
        sign_a = req_funct3 inside {F3Mul, F3Mulh, F3Mulhsu, F3Div, F3Rem};
        sign_b = req_funct3 inside {F3Mul, F3Mulh, F3Div, F3Rem};
        ext_a  = {sign_a & req_rs1[XLEN-1], req_rs1};
        ext_b  = {sign_b & req_rs2[XLEN-1], req_rs2};

        div_by_zero  = req_funct3[2] && (req_rs2 == '0);
        div_overflow = (req_funct3 inside {F3Div, F3Rem}) && (req_rs1 == MinInt) &&
                       (req_rs2 == AllOnes);
        special      = div_by_zero || div_overflow;

        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (div_by_zero) begin
            special_data = req_funct3[1] ? req_rs1 : AllOnes;
        end else begin
            special_data = req_funct3[1] ? '0 : MinInt;
        end
    end

    // ready wins over the timeout in the last counted cycle.
    assign timeout = (state_q == StWait) && !ready && (cnt_q == CntMax);

`ifdef MDU_RESULT_CACHE_EN
    // Ops in one class share extension and unit mode, so they share a unit result.
    function automatic logic [2:0] op_class(input logic [2:0] f3);
        case (f3)
            F3Mul, F3Mulh: op_class = 3'd0;
            F3Mulhsu:      op_class = 3'd1;
            F3Mulhu:       op_class = 3'd2;
            F3Div, F3Rem:  op_class = 3'd3;
            default:       op_class = 3'd4;
        endcase
    endfunction

    logic              cache_valid_q;
    logic [XLEN-1:0]   cache_rs1_q, cache_rs2_q;
    logic [2:0]        cache_class_q;
    logic [2*XLEN+1:0] cache_val_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cache_valid_q <= 1'b0;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_class_q <= '0;
            cache_val_q   <= '0;
        end else if (timeout) begin
            cache_valid_q <= 1'b0;
        end else if ((state_q == StWait) && ready) begin
            cache_valid_q <= 1'b1;
            cache_rs1_q   <= opa_q[XLEN-1:0];
            cache_rs2_q   <= opb_q[XLEN-1:0];
            cache_class_q <= op_class(funct3_q);
            cache_val_q   <= {Aval, Bval};
        end
    end

    assign cache_hit = cache_valid_q && (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q) &&
                       (op_class(req_funct3) == cache_class_q);
    assign cache_val = cache_val_q;
`else
    assign cache_hit = 1'b0;
    assign cache_val = '0;
`endif

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid && (special || cache_hit)) begin
                    state_d = StDone;
                end else if (req_valid && ready) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (ready || timeout) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy       = (state_q != StIdle);
        Run        = (state_q == StLaunch);
        resp_valid = (state_q == StDone);
    end

    // Operand latch, wait counter and result register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            opa_q       <= '0;
            opb_q       <= '0;
            div_q       <= 1'b0;
            funct3_q    <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            err_q <= timeout;
            if (state_q != StWait) begin
                cnt_q <= '0;
            end else if (!ready && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + CntW'(1);
            end

            if ((state_q == StIdle) && req_valid) begin
                if (special) begin
                    resp_data_q <= special_data;
                end else if (cache_hit) begin
                    resp_data_q <= select_result(req_funct3, cache_val);
                end else if (ready) begin
                    opa_q    <= ext_a;
                    opb_q    <= ext_b;
                    div_q    <= req_funct3[2];
                    funct3_q <= req_funct3;
                end
            end else if (state_q == StWait) begin
                if (ready) begin
                    resp_data_q <= select_result(funct3_q, {Aval, Bval});
                end else if (timeout) begin
                    resp_data_q <= '0;
                end
            end
        end
    end

    assign opA       = opa_q;
    assign opB       = opb_q;
    assign div       = div_q;
    assign resp_data = resp_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: random and directed RV32M requests against a 32-bit arithmetic reference.
// A stub 33-bit unit answers Run after a programmable delay, or never in timeout mode.
module tb_muldiv_sequencer;

    localparam int T = 80;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2;
    logic        busy, resp_valid, err, Run, div;
    logic [31:0] resp_data;
    logic [32:0] opA, opB, Aval, Bval;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    muldiv_sequencer #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (T)
    ) u_dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .err        (err),
        .Run        (Run),
        .div        (div),
        .opA        (opA),
        .opB        (opB),
        .Aval       (Aval),
        .Bval       (Bval),
        .ready      (ready)
    );

    // Stub unit: signed 33-bit multiply/divide, result after unit_lat idle counts.
    logic        unit_kill = 1'b1;
    logic        unit_dead = 1'b0;
    int          unit_lat  = 0;
    int          unit_cnt  = 0;
    int          run_cnt   = 0;
    logic        u_div;
    logic [32:0] u_a, u_b;

    function automatic logic [65:0] unit_calc(input logic d, input logic [32:0] a,
                                              input logic [32:0] b);
        logic signed [65:0] pa, pb, prod;
        logic signed [32:0] sa, sb, q, r;
        if (!d) begin
            pa = {{33{a[32]}}, a};
            pb = {{33{b[32]}}, b};
            prod = pa * pb;
            return prod;
        end
        sa = a;
        sb = b;
        if (sb == 0) return '0;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    always @(posedge Clk) begin
        if (Run) run_cnt <= run_cnt + 1;
        if (unit_kill) begin
            ready    <= 1'b1;
            unit_cnt <= 0;
            Aval     <= '0;
            Bval     <= '0;
        end else if (Run) begin
            ready    <= 1'b0;
            unit_cnt <= unit_dead ? -1 : unit_lat;
            u_a      <= opA;
            u_b      <= opB;
            u_div    <= div;
        end else if (!ready && unit_cnt > 0) begin
            unit_cnt <= unit_cnt - 1;
        end else if (!ready && unit_cnt == 0) begin
            ready        <= 1'b1;
            {Aval, Bval} <= unit_calc(u_div, u_a, u_b);
        end
    end

    task automatic check_val(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] s1, s2, ps;
        logic [63:0]        u1, u2, pu;
        s1 = $signed(a);
        s2 = $signed(b);
        u1 = {32'b0, a};
        u2 = {32'b0, b};
        case (f3)
            3'b000: begin ps = s1 * s2; return ps[31:0]; end
            3'b001: begin ps = s1 * s2; return ps[63:32]; end
            3'b010: begin ps = s1 * $signed(u2); return ps[63:32]; end
            3'b011: begin pu = u1 * u2; return pu[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                ps = s1 / s2; return ps[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFFFFFF;
                pu = u1 / u2; return pu[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                ps = s1 % s2; return ps[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = u1 % u2; return pu[31:0];
            end
        endcase
    endfunction

    // Result-cache model: last launched operands and op class.
    logic        c_valid = 1'b0;
    logic [31:0] c_rs1, c_rs2;
    int          c_cls;

    function automatic int op_cls(input logic [2:0] f3);
        if (f3 <= 3'd1) return 0;
        if (f3 == 3'd2) return 1;
        if (f3 == 3'd3) return 2;
        if (f3 == 3'd4 || f3 == 3'd6) return 3;
        return 4;
    endfunction

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int lat);
        int          n, runs0;
        logic        special, hit, got, busy_ok, launched, exp_err;
        logic [31:0] exp;
        logic [32:0] exp_a, exp_b;
        @(negedge Clk);
        runs0      = run_cnt;
        unit_lat   = lat;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        special = f3[2] && (b == 0 ||
                  ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
        hit = 1'b0;
`ifdef MDU_RESULT_CACHE_EN
        hit = c_valid && c_rs1 == a && c_rs2 == b && c_cls == op_cls(f3);
`endif
        launched = !special && !hit;
        exp_err  = launched && unit_dead;
        exp      = exp_err ? 32'h0 : ref_result(f3, a, b);
        exp_a    = {(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}) & a[31], a};
        exp_b    = {(f3 inside {3'd0, 3'd1, 3'd4, 3'd6}) & b[31], b};
        n = 1;
        got = 1'b0;
        busy_ok = 1'b1;
        while (!got && n < T + 20) begin
            @(negedge Clk);
            n++;
            if (resp_valid) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check_val("resp_seen", got, 1);
        check_val("busy_wait", busy_ok, 1);
        check_val("busy_resp", busy, 1);
        check_val("data", resp_data, exp);
        check_val("err", err, exp_err);
        check_val("runs", run_cnt - runs0, launched ? 1 : 0);
        if (exp_err) begin
            check_val("lat_timeout", (n >= T + 2 && n <= T + 5), 1);
        end else if (launched) begin
            // IDLE + LAUNCH + DONE + WAIT cycles (ready low lat+1 cycles, then the sampling one).
            check_val("lat_norm", n, lat + 5);
        end else begin
            check_val("lat_fast", n, 2);
        end
        if (launched) begin
            check_val("opA", opA, exp_a);
            check_val("opB", opB, exp_b);
            check_val("div", div, f3[2]);
        end
        req_valid = 1'b0;
        @(negedge Clk);
        check_val("pulse", resp_valid, 0);
        check_val("idle", busy, 0);
        check_val("hold", resp_data, exp);
        if (exp_err) begin
            c_valid = 1'b0;
        end else if (launched) begin
            c_valid = 1'b1;
            c_rs1 = a;
            c_rs2 = b;
            c_cls = op_cls(f3);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen;
        Reset      = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        repeat (3) @(negedge Clk);
        check_val("rst_ctl", {busy, resp_valid, Run, err, div}, 0);
        check_val("rst_data", resp_data, 0);
        check_val("rst_ops", {opA, opB}, 0);
        Reset     = 1'b0;
        unit_kill = 1'b0;

        do_op(3'b001, 32'hFFFFFFFD, 32'd7, 3);   // MULH -3 * 7
        do_op(3'b000, 32'd0, 32'd500, 2);        // MUL 0 * 500
        do_op(3'b101, 32'd9, 32'd0, 1);          // DIVU by zero
        do_op(3'b111, 32'd9, 32'd0, 1);          // REMU by zero
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 1);
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 1);
        do_op(3'b100, 32'hFFFFFFF9, 32'd2, 4);   // DIV -7 / 2
        do_op(3'b110, 32'hFFFFFFF9, 32'd2, 0);   // REM -7 % 2
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        do_op(3'b001, 32'h12345678, 32'h9ABCDEF0, 3);
        do_op(3'b000, 32'h12345678, 32'h9ABCDEF0, 3);

        // Unit never answers.
        unit_dead = 1'b1;
        do_op(3'b000, 32'd5, 32'd6, 0);
        unit_dead = 1'b0;
        unit_kill = 1'b1;
        @(negedge Clk);
        unit_kill = 1'b0;

        // Reset while waiting on the unit aborts the op.
        do_op(3'b101, 32'd3, 32'd0, 0);
        @(negedge Clk);
        unit_lat   = 30;
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_rs1    = 32'd3;
        req_rs2    = 32'd4;
        repeat (5) @(negedge Clk);
        check_val("rst_pre_busy", busy, 1);
        Reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge Clk);
        check_val("rst_mid_ctl", {busy, resp_valid, Run, err, div}, 0);
        check_val("rst_mid_data", resp_data, 0);
        check_val("rst_mid_ops", {opA, opB}, 0);
        Reset     = 1'b0;
        unit_kill = 1'b1;
        c_valid   = 1'b0;
        seen      = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            unit_kill = 1'b0;
            if (resp_valid) seen = 1'b1;
        end
        check_val("rst_no_resp", seen, 0);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op(f3, a, b, $urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) do_op(f3 ^ 3'b010, a, b, $urandom_range(0, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
